// File: rtl/sd_pkg.sv
// Shared types and constants for the SD command-line engine.
// Holds response codes, FSM states, the CRC7 polynomial and token widths.
package sd_pkg;

  typedef enum logic [1:0] {
    RESP_NONE        = 2'b00,
    RESP_SHORT       = 2'b01,
    RESP_LONG        = 2'b10,
    RESP_SHORT_NOCRC = 2'b11
  } resp_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_TX,
    S_WAIT,
    S_RX,
    S_GAP
  } state_e;

  localparam logic [6:0] CRC7_POLY = 7'h09;

  localparam int TOK_S    = 48;
  localparam int TOK_L    = 136;
  localparam int CRC_LO   = 8;
  localparam int LONG_HDR = 8;

endpackage

// File: rtl/sd_crc7_serial.sv
// Bit-serial CRC7 (x^7 + x^3 + 1), init zero.
// clr has priority over en.
module sd_crc7_serial
  import sd_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       clr,
  input  logic       en,
  input  logic       din,
  output logic [6:0] crc
);

  logic fb;
  assign fb = din ^ crc[6];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      crc <= '0;
    end else if (clr) begin
      crc <= '0;
    end else if (en) begin
      crc <= {crc[5:0], 1'b0} ^ ({7{fb}} & CRC7_POLY);
    end
  end

endmodule

// File: rtl/sd_cmd_engine.sv
// SD CMD-line engine: command TX with CRC7, optional response RX, Ncr timeout, Ncc gap.
// Define SD_CMD_RESP_CRC_CHECK_EN to check the CRC7 of short/long responses.
module sd_cmd_engine
  import sd_pkg::*;
#(
  parameter int TIMEOUT_CYC = 64,
  parameter int GAP_CYC     = 8,
  parameter int RESP_W      = 136
) (
  input  logic              sd_clk,
  input  logic              reset,
  input  logic              cmd_start,
  input  logic [5:0]        cmd_index,
  input  logic [31:0]       cmd_arg,
  input  logic [1:0]        resp_type,
  output logic              busy,
  output logic              done,
  output logic              timeout,
  output logic              resp_err,
  output logic [RESP_W-1:0] resp_data,
  output logic              sd_cmd_out,
  output logic              sd_cmd_oe,
  input  logic              sd_cmd_in
);

  localparam int WCW = $clog2(TIMEOUT_CYC + 1);
  localparam int GCW = $clog2(GAP_CYC + 1);

  localparam logic [7:0] TX_CRC_AT = 8'(TOK_S - CRC_LO - 1);
  localparam logic [7:0] TX_LAST   = 8'(TOK_S - 1);
  localparam logic [7:0] RX_S_LAST = 8'(TOK_S - 1);
  localparam logic [7:0] RX_L_LAST = 8'(TOK_L - 1);
  localparam logic [7:0] RX_L_LO   = 8'(LONG_HDR);
  localparam logic [7:0] RX_L_HI   = 8'(TOK_L - CRC_LO - 1);

  state_e         state;
  resp_e          rt;
  logic [47:0]    tx_sr;
  logic [7:0]     bit_cnt;
  logic [WCW-1:0] wait_cnt;
  logic [GCW-1:0] gap_cnt;
  logic [6:0]     tx_crc;
  logic           tx_crc_en;
  logic           is_long;
  logic           rx_last;
  logic           crc_bad;

  assign is_long = (rt == RESP_LONG);
  assign rx_last = bit_cnt == (is_long ? RX_L_LAST : RX_S_LAST);

  // Start bit is zero, so clearing in IDLE already accounts for it.
  assign tx_crc_en = (state == S_TX) && (bit_cnt < TX_CRC_AT);

  sd_crc7_serial u_tx_crc (
    .clk   (sd_clk),
    .reset (reset),
    .clr   (state == S_IDLE),
    .en    (tx_crc_en),
    .din   (tx_sr[47]),
    .crc   (tx_crc)
  );

`ifdef SD_CMD_RESP_CRC_CHECK_EN
  logic [6:0] rx_crc;
  logic       rx_crc_en;
  logic       rx_win;

  assign rx_win = is_long
    ? (bit_cnt >= RX_L_LO) && (bit_cnt <= RX_L_HI)
    : (bit_cnt <= TX_CRC_AT);

  assign rx_crc_en =
    ((state == S_WAIT) && !sd_cmd_in && !is_long) ||
    ((state == S_RX) && rx_win);

  sd_crc7_serial u_rx_crc (
    .clk   (sd_clk),
    .reset (reset),
    .clr   (state == S_IDLE),
    .en    (rx_crc_en),
    .din   (sd_cmd_in),
    .crc   (rx_crc)
  );

  // In the end-bit cycle resp_data[6:0] holds the received CRC bits.
  assign crc_bad = ((rt == RESP_SHORT) || (rt == RESP_LONG)) &&
                   (rx_crc != resp_data[6:0]);
`else
  assign crc_bad = 1'b0;
`endif

  always_ff @(posedge sd_clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      rt         <= RESP_NONE;
      tx_sr      <= '0;
      bit_cnt    <= '0;
      wait_cnt   <= '0;
      gap_cnt    <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      timeout    <= 1'b0;
      resp_err   <= 1'b0;
      resp_data  <= '0;
      sd_cmd_out <= 1'b1;
      sd_cmd_oe  <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (cmd_start) begin
            rt         <= resp_e'(resp_type);
            tx_sr      <= {1'b1, cmd_index, cmd_arg, 7'd0, 1'b1, 1'b0};
            bit_cnt    <= '0;
            timeout    <= 1'b0;
            resp_err   <= 1'b0;
            resp_data  <= '0;
            busy       <= 1'b1;
            sd_cmd_oe  <= 1'b1;
            sd_cmd_out <= 1'b0;
            state      <= S_TX;
          end
        end
        S_TX: begin
          bit_cnt <= bit_cnt + 8'd1;
          if (bit_cnt == TX_LAST) begin
            sd_cmd_oe  <= 1'b0;
            sd_cmd_out <= 1'b1;
            wait_cnt   <= WCW'(1);
            gap_cnt    <= '0;
            state      <= (rt == RESP_NONE) ? S_GAP : S_WAIT;
          end else if (bit_cnt == TX_CRC_AT) begin
            sd_cmd_out <= tx_crc[6];
            tx_sr      <= {tx_crc[5:0], 1'b1, 41'd0};
          end else begin
            sd_cmd_out <= tx_sr[47];
            tx_sr      <= {tx_sr[46:0], 1'b0};
          end
        end
        S_WAIT: begin
          if (!sd_cmd_in) begin
            resp_data <= {resp_data[RESP_W-2:0], sd_cmd_in};
            bit_cnt   <= 8'd1;
            state     <= S_RX;
          end else if (wait_cnt == WCW'(TIMEOUT_CYC)) begin
            timeout <= 1'b1;
            gap_cnt <= '0;
            state   <= S_GAP;
          end else begin
            wait_cnt <= wait_cnt + WCW'(1);
          end
        end
        S_RX: begin
          resp_data <= {resp_data[RESP_W-2:0], sd_cmd_in};
          if (rx_last) begin
            resp_err <= !sd_cmd_in || crc_bad;
            gap_cnt  <= '0;
            state    <= S_GAP;
          end else begin
            bit_cnt <= bit_cnt + 8'd1;
          end
        end
        S_GAP: begin
          if (gap_cnt == GCW'(GAP_CYC - 1)) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= S_IDLE;
          end else begin
            gap_cnt <= gap_cnt + GCW'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
